// File: rtl/mips_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the MIPS run controller.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } ctrl_state_e;

  localparam logic [5:0] HALT_OPCODE_DEF  = 6'b111111;
  localparam int         DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/ctrl_sat_counter.sv
// Up-counter with synchronous clear and active-low reset; holds at all-ones instead of wrapping.
module ctrl_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/mips_run_controller.sv
// MIPS pipeline run controller: run/step sequencing, HALT detect, pipeline drain and cycle counting.
// Define MIPS_CTRL_WATCHDOG_EN to add a watchdog that forces a drain after WDOG_CYCLES advances.
module mips_run_controller
  import mips_ctrl_pkg::*;
#(
  parameter int                   LEN          = 32,
  parameter int                   NB_OPCODE    = 6,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = HALT_OPCODE_DEF,
  parameter int                   DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int                   NB_CYCLES    = 32
`ifdef MIPS_CTRL_WATCHDOG_EN
  ,
  parameter int                   WDOG_CYCLES  = 65535
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_mode_step,
  input  logic                 i_step,
  input  logic [LEN-1:0]       i_instruction,
  output logic                 o_pipe_en,
  output logic                 o_pc_en,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [NB_CYCLES-1:0] o_cycle_count,
  output logic [2:0]           o_state
);

  localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_e         state_q, state_d;
  logic                mode_step_q, mode_step_d;
  logic [NB_DRAIN-1:0] drain_cnt_q, drain_cnt_d;
  logic                pipe_en_q, pipe_en_d;
  logic                pc_en_q, pc_en_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                halt_at_if;
  logic                wdog_hit;
  logic                unused_instr_bits;

  // HALT only counts while a fetch is enabled, so the frozen HALT word is never seen twice.
  assign halt_at_if = pc_en_q && (i_instruction[LEN-1 -: NB_OPCODE] == HALT_OPCODE);
  assign unused_instr_bits = ^i_instruction[LEN-NB_OPCODE-1:0];

`ifdef MIPS_CTRL_WATCHDOG_EN
  localparam int NB_WDOG = $clog2(WDOG_CYCLES + 1);
  logic [NB_WDOG-1:0] run_cnt;

  ctrl_sat_counter #(.WIDTH(NB_WDOG)) u_run_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (state_q == IDLE),
    .i_en    (pc_en_q),
    .o_count (run_cnt)
  );

  assign wdog_hit = pc_en_q && !halt_at_if && (run_cnt == NB_WDOG'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  ctrl_sat_counter #(.WIDTH(NB_CYCLES)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (state_q == IDLE),
    .i_en    (pipe_en_q),
    .o_count (o_cycle_count)
  );

  always_comb begin
    state_d     = state_q;
    mode_step_d = mode_step_q;
    drain_cnt_d = drain_cnt_q;
    timeout_d   = timeout_q | wdog_hit;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d     = i_mode_step ? STEP_WAIT : RUN;
          mode_step_d = i_mode_step;
        end
      end
      RUN: begin
        if (halt_at_if || wdog_hit) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      STEP_WAIT: begin
        if (i_step) state_d = STEP_EXEC;
      end
      STEP_EXEC: begin
        if (halt_at_if || wdog_hit) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          state_d = STEP_WAIT;
        end
      end
      DRAIN: begin
        if (pipe_en_q) begin
          drain_cnt_d = drain_cnt_q + NB_DRAIN'(1);
          if (drain_cnt_d == NB_DRAIN'(DRAIN_CYCLES)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A step pulse only advances the drain when it arrives in DRAIN itself.
    pc_en_d   = (state_d == RUN) || (state_d == STEP_EXEC);
    pipe_en_d = pc_en_d ||
                ((state_d == DRAIN) && (!mode_step_d || ((state_q == DRAIN) && i_step)));
    running_d = state_d inside {RUN, STEP_WAIT, STEP_EXEC, DRAIN};
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      mode_step_q <= 1'b0;
      drain_cnt_q <= '0;
      pipe_en_q   <= 1'b0;
      pc_en_q     <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_step_q <= mode_step_d;
      drain_cnt_q <= drain_cnt_d;
      pipe_en_q   <= pipe_en_d;
      pc_en_q     <= pc_en_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_pipe_en = pipe_en_q;
  assign o_pc_en   = pc_en_q;
  assign o_running = running_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;
  assign o_state   = state_q;

endmodule
